// File: rtl/scan_bridge_mc.sv
// Scan-chain to multi-channel memory/CSR bridge: oversampled two-phase scan pads,
// a command/response frame shift register and a single-access FSM with ready timeout.
//
// state  | meaning
// IDLE   | waiting for a load_chip edge; strobes low
// ACCESS | one-hot strobe held on the latched channel until ready or timeout
module scan_bridge_mc #(
   parameter int   N_CH    = 4,
   parameter int   ADDR_W  = 11,
   parameter int   DATA_W  = 32,
   parameter int   TIMEOUT = 64,
   parameter logic SCAN_ID = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   scan_id,
   input  logic                   scan_phi,
   input  logic                   scan_phi_bar,
   input  logic                   scan_data_in,
   output logic                   scan_data_out,
   input  logic                   scan_load_chip,
   input  logic                   scan_load_chain,
   output logic [N_CH-1:0]        ch_ren,
   output logic [N_CH-1:0]        ch_wen,
   output logic [ADDR_W-1:0]      ch_addr,
   output logic [DATA_W-1:0]      ch_wdata,
   input  logic [N_CH*DATA_W-1:0] ch_rdata,
   input  logic [N_CH-1:0]        ch_ready,
   output logic                   busy,
   output logic                   protocol_err
);
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int FRAME_W = 2 + CH_W + ADDR_W + DATA_W;
   localparam int TMR_W   = $clog2(TIMEOUT);
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [N_CH-1:0] CH_ONE = N_CH'(1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t state_q, state_d;

   // s1/s2: two-flop synchronisers; s3 holds the previous sample of edge-detected pads
   logic [5:0] s1, s2;
   logic [3:0] s3;
   logic       sel, phi_e, pb_e, chip_e, chain_e;

   logic [FRAME_W-1:0] chain, resp;
   logic               cap;
   logic [1:0]         status_q;
   logic [CH_W-1:0]    chan_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q, wdata_q;
   logic               rd_q;
   logic [TMR_W-1:0]   timer_q;

   logic [1:0]        cmd_op;
   logic [CH_W-1:0]   cmd_chan;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_valid, chan_ok, ready_sel;
   logic [DATA_W-1:0] rdata_sel;
   logic              accept, done_ok, done_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= {scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain};
         s2 <= s1;
         s3 <= {s2[4], s2[3], s2[1], s2[0]};
      end
   end

   assign sel     = (s2[5] == SCAN_ID);
   assign phi_e   = sel & s2[4] & ~s3[3];
   assign pb_e    = sel & s2[3] & ~s3[2];
   assign chip_e  = sel & s2[1] & ~s3[1];
   assign chain_e = sel & s2[0] & ~s3[0];

   assign cmd_op    = chain[FRAME_W-1 -: 2];
   assign cmd_chan  = chain[FRAME_W-3 -: CH_W];
   assign cmd_addr  = chain[DATA_W +: ADDR_W];
   assign cmd_data  = chain[DATA_W-1:0];
   assign cmd_valid = (cmd_op == OP_WR) || (cmd_op == OP_RD);
   assign chan_ok   = int'(cmd_chan) < N_CH;

   assign busy      = (state_q == ACCESS);
   assign resp      = {(busy ? 2'b01 : status_q), chan_q, addr_q, data_q};
   assign rdata_sel = ch_rdata[chan_q*DATA_W +: DATA_W];
   assign ready_sel = ch_ready[chan_q];
   assign ch_addr   = addr_q;
   assign ch_wdata  = wdata_q;

   // load_chip wins over load_chain when both edges land in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain         <= '0;
         cap           <= 1'b0;
         scan_data_out <= 1'b0;
         protocol_err  <= 1'b0;
      end else begin
         if (phi_e && pb_e) begin
            protocol_err <= 1'b1;
         end else begin
            if (phi_e) cap <= s2[2];
            if (pb_e) begin
               chain         <= {chain[FRAME_W-2:0], cap};
               scan_data_out <= chain[FRAME_W-2];
            end
         end
         if (chain_e && !chip_e) begin
            chain         <= resp;
            scan_data_out <= resp[FRAME_W-1];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done_ok = 1'b0;
      done_to = 1'b0;
      case (state_q)
         IDLE: begin
            if (chip_e && cmd_valid && chan_ok) begin
               accept  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (ready_sel) begin
               done_ok = 1'b1;
               state_d = IDLE;
            end else if (timer_q == '0) begin
               done_to = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         status_q <= 2'b00;
         chan_q   <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         timer_q  <= '0;
         ch_wen   <= '0;
         ch_ren   <= '0;
      end else begin
         state_q <= state_d;
         if (chip_e && state_q == IDLE && !accept) status_q <= cmd_valid ? 2'b11 : 2'b00;
         if (chip_e && state_q == ACCESS) status_q <= 2'b01;
         if (accept) begin
            rd_q    <= (cmd_op == OP_RD);
            chan_q  <= cmd_chan;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_data;
            timer_q <= TMR_W'(TIMEOUT - 1);
            ch_wen  <= (cmd_op == OP_WR) ? (CH_ONE << cmd_chan) : '0;
            ch_ren  <= (cmd_op == OP_RD) ? (CH_ONE << cmd_chan) : '0;
         end else if (state_q == ACCESS) begin
            timer_q <= timer_q - 1'b1;
         end
         // a completion overrides the BUSY_DROP status of a command dropped mid-access
         if (done_ok) begin
            status_q <= 2'b00;
            data_q   <= rd_q ? rdata_sel : wdata_q;
            ch_wen   <= '0;
            ch_ren   <= '0;
         end
         if (done_to) begin
            status_q <= 2'b10;
            data_q   <= '0;
            ch_wen   <= '0;
            ch_ren   <= '0;
         end
      end
   end
endmodule

// File: doc/scan_bridge_mc.md
Name: scan_bridge_mc

Overview:
- Parametrised multi-channel successor of the scan-to-memory/register bridge.
- Oversamples the two-phase scan pads on the core clock and shifts a command frame in.
- On scan_load_chip, issues one read or write to one of N_CH target channels (SRAMs or CSR blocks), with a ready handshake and timeout.
- Returns a status/data frame on scan_load_chain, to be shifted out on scan_data_out.

Parameters:
- N_CH, 4: number of target channels. CH_W = max(1, clog2(N_CH)) is derived.
- ADDR_W, 11: shared channel address width.
- DATA_W, 32: channel data width.
- TIMEOUT, 64: cycles to wait for ch_ready before aborting. Legal range is 2 or more.
- SCAN_ID, 1: scan_id value that selects this bridge.
- Derived frame width: FRAME_W = 2 + CH_W + ADDR_W + DATA_W (47 at defaults).

Ports:
- clk  in  1  core clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- scan_id  in  1  chip select; the block is active only when it equals SCAN_ID.
- scan_phi  in  1  scan master clock pad; asynchronous.
- scan_phi_bar  in  1  scan slave clock pad; asynchronous.
- scan_data_in  in  1  serial input.
- scan_data_out  out  1  serial output, registered.
- scan_load_chip  in  1  rising edge: execute the command in the chain.
- scan_load_chain  in  1  rising edge: load the response into the chain.
- ch_ren  out  N_CH  per-channel read strobe.
- ch_wen  out  N_CH  per-channel write strobe.
- ch_addr  out  ADDR_W  shared address.
- ch_wdata  out  DATA_W  shared write data.
- ch_rdata  in  N_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W].
- ch_ready  in  N_CH  per-channel completion.
- busy  out  1  access in progress.
- protocol_err  out  1  sticky; set on overlapping phi/phi_bar edges.

Behaviour:
- Input synchronisation:
  - scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip and scan_load_chain each pass through a 2-flop synchroniser.
  - A rising edge is detected as sync2 & ~sync3.
  - An action therefore occurs 3 clk cycles after the pad is first sampled high.
- Gating: when synchronised scan_id != SCAN_ID, every edge is ignored and scan_data_out holds its value.
- phi edge: latch the synchronised scan_data_in into the capture bit cap.
- phi_bar edge:
  - chain <= {chain[FRAME_W-2:0], cap}.
  - scan_data_out <= new chain[FRAME_W-1].
  - The frame is MSB-first.
- phi and phi_bar edges in the same cycle: no capture, no shift, protocol_err <= 1. protocol_err clears only on reset.
- Command frame fields: op[1:0] at the MSB, then chan[CH_W], addr[ADDR_W], data[DATA_W].
- op encoding: 00 NOP, 01 WRITE, 10 READ, 11 reserved (treated as NOP).
- Response frame fields: status[1:0], chan, addr, data.
  - chan and addr are those of the last accepted command.
  - data is the read data, or the written data for a WRITE.
- status codes: 00 OK, 01 BUSY_DROP, 10 TIMEOUT, 11 BAD_CHAN.
- FSM states: IDLE and ACCESS.
  - IDLE, load_chip edge, op NOP: status <= 00, no access.
  - IDLE, load_chip edge, chan >= N_CH: status <= 11, no access.
  - IDLE, load_chip edge, valid WRITE or READ: latch op, chan, addr and data; go to ACCESS; clear the timer.
  - ACCESS:
    - ch_wen[chan] or ch_ren[chan] is high (one-hot, registered), and ch_addr/ch_wdata are held stable.
    - If ch_ready[chan] is high in a cycle: for a READ capture ch_rdata slice chan; status <= 00; go to IDLE with the strobe deasserted the next cycle. The minimum strobe width is 1 cycle.
    - If the timer reaches TIMEOUT-1 without ready: status <= 10, data <= 0, go to IDLE.
    - ch_ready of non-selected channels is ignored.
- busy = (state == ACCESS).
- load_chip edge while in ACCESS: the command is dropped and status <= 01. The access in flight is unaffected, and its completion overwrites status.
- load_chain edge: chain <= response frame, and scan_data_out <= its MSB the same cycle. During ACCESS the response carries status 01 and the previous data.
- load_chip and load_chain edges in the same cycle: load_chip is processed and load_chain is ignored.
- Shifting is permitted during ACCESS; the chain is independent of the latched command.
- Reset (asynchronous):
  - chain, cap, status, data, addr and chan go to 0; state goes to IDLE.
  - All ch_ren/ch_wen, busy, scan_data_out and protocol_err go to 0 immediately, including mid-access.

Test Plan:
- Shift 47 bits for WRITE, chan 2, addr 0x155, data 0xDEADBEEF, then pulse load_chip; ch2 returns ready after 3 cycles. Required: ch_wen=4'b0100 for 4 cycles, ch_addr=0x155, ch_wdata=0xDEADBEEF. Then load_chain and shift out: status 00, chan 2, addr 0x155, data 0xDEADBEEF.
- READ, chan 1, addr 0x7FF, with ch1 ready in the same cycle as the strobe and rdata 0x12345678. Required: ch_ren=4'b0010 for 1 cycle, and the response data is 0x12345678 with status 00.
- READ on chan 3 with ch_ready tied to 0. Required: ch_ren high for exactly 64 cycles, then deasserted; response status 10, data 0.
- With N_CH=3, WRITE to chan 3. Required: no strobe, status 11. Also pulse load_chip during a pending access: status 01 while the access is in flight, and busy stays high.
- Drive phi and phi_bar rising together. Required: chain unchanged, protocol_err=1 until rst_n low. With scan_id=0, a full shift sequence must leave scan_data_out unchanged.
- Assert rst_n low mid-ACCESS. Required: ch_wen, busy and scan_data_out are 0 with no clock edge; after release the FSM is in IDLE and the first response reads status 00 with all fields 0.
